// File: rtl/minimax_mem_port_if.sv
// Core-side fetch and load/store bus of the minimax memory responder.
// The core drives requests through master; the memory port answers through slave.
interface minimax_mem_port_if #(
  parameter int PC_BITS = 13
);
  logic [PC_BITS-1:0] inst_addr;
  logic               inst_regce;
  logic [15:0]        inst;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [3:0]         wmask;
  logic               rreq;
  logic [31:0]        rdata;

  modport master (
    output inst_addr, inst_regce, addr, wdata, wmask, rreq,
    input  inst, rdata
  );

  modport slave (
    input  inst_addr, inst_regce, addr, wdata, wmask, rreq,
    output inst, rdata
  );
endinterface

// File: rtl/minimax_mem_port.sv
// Memory responder for the minimax core: shares one synchronous-read SRAM between
// data stores, data loads and instruction fetch (in that priority), and decodes the exit register.
module minimax_mem_port #(
  parameter int          PC_BITS   = 13,
  parameter logic [31:0] EXIT_ADDR = 32'hfffffffc
) (
  input  logic               clk,
  input  logic               reset,
  minimax_mem_port_if.slave  core,
  output logic               sram_en,
  output logic [PC_BITS-3:0] sram_addr,
  output logic [31:0]        sram_wdata,
  output logic [3:0]         sram_wmask,
  input  logic [31:0]        sram_rdata,
  output logic               halted,
  output logic               exit_valid,
  output logic [31:0]        exit_code,
  output logic               bus_err
);

  typedef enum logic [1:0] {OP_NONE, OP_FETCH, OP_DLOAD} op_t;

  op_t         last_op;
  logic        last_half;
  logic [15:0] inst_q;
  logic [15:0] inst_lat;
  logic        is_store;
  logic        in_ram;
  logic        exit_store;
  logic        ram_store;
  logic        ram_load;
  logic        err_now;
  logic        unused_ok;

  // Halfword fetches only ever look at bit 1 of the fetch address.
  assign unused_ok = core.inst_addr[0];

  always_comb begin
    is_store   = |core.wmask;
    in_ram     = core.addr[31:PC_BITS] == '0;
    exit_store = (core.wmask == 4'hf) && (core.addr == EXIT_ADDR);
    ram_store  = is_store && in_ram;
    ram_load   = core.rreq && !is_store && in_ram;
    err_now    = (is_store && !in_ram && !exit_store) ||
                 (core.rreq && !is_store && !in_ram) ||
                 (is_store && !exit_store && (core.addr == EXIT_ADDR)) ||
                 (core.rreq && is_store);
  end

  // Exit stores and unmapped accesses leave the slot to the fetch path.
  always_comb begin
    sram_en    = !reset && !halted;
    sram_wmask = (sram_en && ram_store) ? core.wmask : 4'h0;
    sram_wdata = core.wdata;
    sram_addr  = (ram_store || ram_load) ? core.addr[PC_BITS-1:2]
                                         : core.inst_addr[PC_BITS-1:2];
    inst_lat   = 16'h0000;
    if (last_op == OP_FETCH)
      inst_lat = last_half ? sram_rdata[31:16] : sram_rdata[15:0];
  end

  assign core.rdata = (last_op == OP_DLOAD) ? sram_rdata : 32'h0;
  assign core.inst  = inst_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_op    <= OP_NONE;
      last_half  <= 1'b0;
      inst_q     <= 16'h0000;
      halted     <= 1'b0;
      exit_valid <= 1'b0;
      exit_code  <= 32'h0;
      bus_err    <= 1'b0;
    end else begin
      exit_valid <= 1'b0;
      last_half  <= core.inst_addr[1];
      if (core.inst_regce)
        inst_q <= inst_lat;
      if (halted || is_store)
        last_op <= OP_NONE;
      else if (ram_load)
        last_op <= OP_DLOAD;
      else
        last_op <= OP_FETCH;
      if (exit_store && !halted) begin
        halted     <= 1'b1;
        exit_valid <= 1'b1;
        exit_code  <= core.wdata;
      end
      if (err_now)
        bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_minimax_mem_port.sv
// Scoreboard bench for minimax_mem_port: a word-array reference model predicts every
// cycle's SRAM command and core-visible outputs; a negedge monitor checks them.
module tb_minimax_mem_port;
  localparam int          PCB   = 13;
  localparam int          WORDS = 2048;
  localparam logic [31:0] EXIT  = 32'hfffffffc;

  typedef struct {
    logic        en;
    logic [10:0] saddr;
    logic [3:0]  swmask;
    logic [31:0] swdata;
    logic [31:0] rdata;
    logic [15:0] inst;
    logic        halted;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        bus_err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        sram_en;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wmask;
  logic [31:0] sram_rdata;
  logic        halted;
  logic        exit_valid;
  logic [31:0] exit_code;
  logic        bus_err;
  logic        load_img;

  logic [31:0] init_img [0:WORDS-1];
  logic [31:0] sram_mem [0:WORDS-1];

  // Reference model state: memory image plus what the core should see next cycle.
  logic [31:0] m_mem [0:WORDS-1];
  logic [15:0] m_inst_lat;
  logic [31:0] m_rdata;
  logic [15:0] m_inst;
  logic        m_halted;
  logic        m_exit_valid;
  logic [31:0] m_exit_code;
  logic        m_bus_err;

  exp_t sb [$];
  int   tests;
  int   failed;

  minimax_mem_port_if #(.PC_BITS(PCB)) bus ();

  minimax_mem_port #(.PC_BITS(PCB), .EXIT_ADDR(EXIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .core       (bus.slave),
    .sram_en    (sram_en),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wmask (sram_wmask),
    .sram_rdata (sram_rdata),
    .halted     (halted),
    .exit_valid (exit_valid),
    .exit_code  (exit_code),
    .bus_err    (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < WORDS; i++) sram_mem[i] <= init_img[i];
      sram_rdata <= 32'h0;
    end else if (sram_en) begin
      if (sram_wmask != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compare("sram_en", {31'h0, sram_en}, {31'h0, e.en});
    if (e.en) compare("sram_addr", {21'h0, sram_addr}, {21'h0, e.saddr});
    compare("sram_wmask", {28'h0, sram_wmask}, {28'h0, e.swmask});
    if (e.swmask != 4'h0) compare("sram_wdata", sram_wdata, e.swdata);
    compare("rdata", bus.rdata, e.rdata);
    compare("inst", {16'h0, bus.inst}, {16'h0, e.inst});
    compare("halted", {31'h0, halted}, {31'h0, e.halted});
    compare("exit_valid", {31'h0, exit_valid}, {31'h0, e.exit_valid});
    compare("exit_code", exit_code, e.exit_code);
    compare("bus_err", {31'h0, bus_err}, {31'h0, e.bus_err});
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  task automatic modelReset();
    m_inst_lat   = 16'h0;
    m_rdata      = 32'h0;
    m_inst       = 16'h0;
    m_halted     = 1'b0;
    m_exit_valid = 1'b0;
    m_exit_code  = 32'h0;
    m_bus_err    = 1'b0;
  endtask

  // Called #1 after a rising edge; drives one cycle, predicts it, and advances the model.
  task automatic applyStimulus(input logic [12:0] ia, input logic rg, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] wm, input logic rr);
    exp_t        e;
    logic        st, inram, exit_st, ramst, ramld;
    logic [31:0] word;
    bus.inst_addr  = ia;
    bus.inst_regce = rg;
    bus.addr       = a;
    bus.wdata      = wd;
    bus.wmask      = wm;
    bus.rreq       = rr;
    st      = wm != 4'h0;
    inram   = a[31:PCB] == '0;
    exit_st = (wm == 4'hf) && (a == EXIT);
    ramst   = st && inram;
    ramld   = rr && !st && inram;
    e.en         = !m_halted;
    e.saddr      = (ramst || ramld) ? a[12:2] : ia[12:2];
    e.swmask     = (!m_halted && ramst) ? wm : 4'h0;
    e.swdata     = wd;
    e.rdata      = m_rdata;
    e.inst       = m_inst;
    e.halted     = m_halted;
    e.exit_valid = m_exit_valid;
    e.exit_code  = m_exit_code;
    e.bus_err    = m_bus_err;
    sb.push_back(e);
    @(posedge clk);
    if (rg) m_inst = m_inst_lat;
    m_inst_lat = 16'h0;
    m_rdata    = 32'h0;
    if (!m_halted) begin
      if (ramst) begin
        for (int b = 0; b < 4; b++)
          if (wm[b]) m_mem[a[12:2]][8*b +: 8] = wd[8*b +: 8];
      end else if (!st && ramld) begin
        m_rdata = m_mem[a[12:2]];
      end else if (!st) begin
        word       = m_mem[ia[12:2]];
        m_inst_lat = ia[1] ? word[31:16] : word[15:0];
      end
    end
    if ((st && !inram && !exit_st) || (rr && !st && !inram) ||
        (st && a == EXIT && wm != 4'hf) || (rr && st))
      m_bus_err = 1'b1;
    m_exit_valid = exit_st && !m_halted;
    if (m_exit_valid) begin
      m_halted    = 1'b1;
      m_exit_code = wd;
    end
    #1;
  endtask

  task automatic idle(input logic [12:0] ia, input logic rg);
    applyStimulus(ia, rg, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic randomCycle(input bit allow_exit);
    logic [12:0] ia;
    logic [31:0] a, wd;
    logic [3:0]  wm;
    logic        rr, rg;
    int          sel;
    ia  = {12'($urandom_range(0, 4095)), 1'b0};
    sel = $urandom_range(0, 19);
    if (sel < 10)      a = {19'h0, 11'($urandom_range(0, 31)), 2'b00};
    else if (sel < 17) a = {19'h0, 11'($urandom_range(0, WORDS - 1)), 2'b00};
    else if (sel < 19) a = 32'h0001_0000 | {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    else               a = EXIT;
    wm = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    if (!allow_exit && a == EXIT && wm == 4'hf) wm = 4'h5;
    rr = 1'($urandom_range(0, 1));
    rg = $urandom_range(0, 3) != 0;
    wd = $urandom;
    applyStimulus(ia, rg, a, wd, wm, rr);
  endtask

  // Asserts reset with a full store still on the bus; outputs must clear at once.
  task automatic doReset();
    reset     = 1'b1;
    bus.addr  = 32'h20;
    bus.wmask = 4'hf;
    bus.rreq  = 1'b1;
    #1;
    compare("reset_rdata", bus.rdata, 32'h0);
    compare("reset_inst", {16'h0, bus.inst}, 32'h0);
    compare("reset_halted", {31'h0, halted}, 32'h0);
    compare("reset_exit_valid", {31'h0, exit_valid}, 32'h0);
    compare("reset_exit_code", exit_code, 32'h0);
    compare("reset_bus_err", {31'h0, bus_err}, 32'h0);
    compare("reset_sram_en", {31'h0, sram_en}, 32'h0);
    compare("reset_sram_wmask", {28'h0, sram_wmask}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    compare("reset_hold_sram_en", {31'h0, sram_en}, 32'h0);
    compare("reset_hold_sram_wmask", {28'h0, sram_wmask}, 32'h0);
    modelReset();
    bus.wmask = 4'h0;
    bus.rreq  = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: bench did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] top_word;
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    bus.inst_addr  = '0;
    bus.inst_regce = 1'b0;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.wmask      = '0;
    bus.rreq       = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      v = $urandom;
      init_img[i] = v;
      m_mem[i]    = v;
    end
    init_img[4]  = 32'hBEEF_1234;
    m_mem[4]     = 32'hBEEF_1234;
    init_img[16] = 32'hFFFF_FFFF;
    m_mem[16]    = 32'hFFFF_FFFF;
    load_img     = 1'b1;
    #2;
    doReset();
    load_img = 1'b0;

    // Halfword selection from a known word.
    idle(13'h0010, 1'b0);
    idle(13'h0012, 1'b1);
    compare("fetch_low_half", {16'h0, bus.inst}, 32'h0000_1234);
    idle(13'h0014, 1'b1);
    compare("fetch_high_half", {16'h0, bus.inst}, 32'h0000_BEEF);

    // Partial store, readback, one-cycle rdata, blocked fetches.
    applyStimulus(13'h0010, 1'b0, 32'h40, 32'h0000_5A5A, 4'b0011, 1'b0);
    applyStimulus(13'h0010, 1'b1, 32'h40, 32'h0, 4'h0, 1'b1);
    compare("store_blocks_fetch", {16'h0, bus.inst}, 32'h0);
    compare("partial_store_load", bus.rdata, 32'hFFFF_5A5A);
    idle(13'h0010, 1'b1);
    compare("rdata_one_cycle", bus.rdata, 32'h0);
    compare("load_blocks_fetch", {16'h0, bus.inst}, 32'h0);

    for (int n = 0; n < 3000; n++) randomCycle(1'b0);

    // Reset in the cycle a load result is on rdata, then fetch at the top of RAM.
    applyStimulus(13'h0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
    compare("load_before_reset", bus.rdata, m_rdata);
    doReset();
    top_word = m_mem[WORDS-1];
    idle(13'h1FFE, 1'b0);
    idle(13'h0000, 1'b1);
    compare("wrap_top_halfword", {16'h0, bus.inst}, {16'h0, top_word[31:16]});

    // Unmapped load and store-with-load errors.
    applyStimulus(13'h0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b1);
    compare("unmapped_load_err", {31'h0, bus_err}, 32'h1);
    compare("unmapped_load_rdata", bus.rdata, 32'h0);
    applyStimulus(13'h0, 1'b0, 32'h20, 32'hCAFE_F00D, 4'hf, 1'b1);
    compare("store_drops_load", bus.rdata, 32'h0);
    applyStimulus(13'h0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    compare("store_with_rreq_written", bus.rdata, 32'hCAFE_F00D);
    compare("bus_err_sticky", {31'h0, bus_err}, 32'h1);

    // Partial exit store is an error, not a halt; full exit store halts once.
    doReset();
    applyStimulus(13'h4, 1'b0, EXIT, 32'h55, 4'h3, 1'b0);
    compare("partial_exit_err", {31'h0, bus_err}, 32'h1);
    compare("partial_exit_no_halt", {31'h0, halted}, 32'h0);
    applyStimulus(13'h4, 1'b0, EXIT, 32'h0, 4'hf, 1'b0);
    compare("exit_pulse", {31'h0, exit_valid}, 32'h1);
    compare("exit_halted", {31'h0, halted}, 32'h1);
    compare("exit_code_zero", exit_code, 32'h0);
    idle(13'h4, 1'b1);
    compare("exit_pulse_once", {31'h0, exit_valid}, 32'h0);
    applyStimulus(13'h4, 1'b0, EXIT, 32'h7, 4'hf, 1'b0);
    compare("exit_code_held", exit_code, 32'h0);
    compare("no_second_pulse", {31'h0, exit_valid}, 32'h0);
    for (int n = 0; n < 30; n++) randomCycle(1'b1);

    doReset();
    applyStimulus(13'h8, 1'b0, EXIT, 32'h1234_5678, 4'hf, 1'b0);
    compare("exit_code_capture", exit_code, 32'h1234_5678);
    for (int n = 0; n < 10; n++) randomCycle(1'b1);

    @(negedge clk);
    #1;
    compare("scoreboard_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/minimax_mem_port.md
# minimax_mem_port

Single-port memory responder for the minimax core: it services the core's instruction-fetch port and its data load/store port from one single-ported, synchronous-read 32-bit SRAM, and decodes the simulation/SoC exit register. It sits between `minimax` and the `gf180mcu_sram_512x32` bank array, replacing ad-hoc behavioural memory. It arbitrates one access per cycle, selects instruction halfwords, holds the core's instruction register, and reports halt/exit status.

## Interface
- `PC_BITS`, 13: byte-address width of RAM; RAM spans `0 .. 2**PC_BITS-1`.
- `EXIT_ADDR`, 32'hfffffffc: store address that halts the system.
- `clk`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst_addr`  in  PC_BITS  core fetch byte address (halfword aligned).
- `inst_regce`  in  1  core strobe: load `inst` from the fetched halfword.
- `inst`  out  16  registered instruction halfword to core.
- `addr`  in  32  core data byte address (word aligned).
- `wdata`  in  32  store data, already lane-aligned by core.
- `wmask`  in  4  byte store strobes; nonzero = store.
- `rreq`  in  1  load request.
- `rdata`  out  32  load data, valid the cycle after `rreq`, else 0.
- `sram_en`  out  1  SRAM access enable.
- `sram_addr`  out  PC_BITS-2  SRAM word address.
- `sram_wdata`  out  32  SRAM write data.
- `sram_wmask`  out  4  SRAM byte write enables; 0 = read.
- `sram_rdata`  in  32  SRAM read data, valid one cycle after a read.
- `halted`  out  1  sticky: exit store seen.
- `exit_valid`  out  1  one-cycle pulse on exit store.
- `exit_code`  out  32  `wdata` of the exit store.
- `bus_err`  out  1  sticky: illegal or unmapped access.

## Operation
- In RAM: `addr[31:PC_BITS] == 0`. Priority per cycle: store > load > fetch; exactly one SRAM access issued.
- Store in RAM: `sram_en=1`, `sram_addr=addr[PC_BITS-1:2]`, `sram_wmask=wmask`, `sram_wdata=wdata`.
- Load in RAM: `sram_en=1`, `sram_wmask=0`, word address from `addr`.
- Otherwise fetch: `sram_en=1`, `sram_wmask=0`, word address `inst_addr[PC_BITS-1:2]`.
- Registered `last_op` ∈ {NONE, FETCH, DLOAD} plus `last_half` (= `inst_addr[1]` at issue). NONE after reset, after any store, and when halted.
- `rdata = sram_rdata` when `last_op==DLOAD`, else 0.
- Fetch halfword `inst_lat = last_half ? sram_rdata[31:16] : sram_rdata[15:0]` when `last_op==FETCH`, else 16'h0000.
- `inst <= inst_lat` on edges where `inst_regce=1`; holds otherwise.
- `wmask==4'hf && addr==EXIT_ADDR`: no SRAM write (access slot goes to fetch); `exit_code<=wdata`, `halted<=1`, `exit_valid` high next cycle only. Repeat exit stores while halted: `exit_code` not updated, no further pulse.
- Halted: `sram_wmask` forced 0, `sram_en` 0, `last_op` NONE (core sees zeros).
- `bus_err` set on: store or load outside RAM (except exit store); partial `wmask` to `EXIT_ADDR`; `rreq` with nonzero `wmask` (store wins, load dropped, `rdata` 0 next cycle). Unmapped loads return 0; unmapped stores dropped.

## Timing
- Reset values: `inst=0`, `halted=0`, `exit_valid=0`, `exit_code=0`, `bus_err=0`, `last_op=NONE`; thus `rdata=0`. `sram_en=0`, `sram_wmask=0` while `reset` high.
- Reset asserted mid-access: in-flight read discarded; first cycle after deassert issues a fetch.
- Fetch at N → halfword on `inst_lat` in N+1 → `inst` valid N+2 if `inst_regce` at N+1.
- Load at N → `rdata` valid N+1 (one cycle only).
- Store at N → written at N's edge; load of same word at N+1 returns new data at N+2.
- Fetch blocked by load/store at N: `inst_lat` 0 in N+1; core stalls/re-fetches.
- Word addresses wrap within RAM: `inst_addr` top halfword `2**PC_BITS-2` reads word `2**(PC_BITS-2)-1` upper half.

## Test plan
- RAM word 4 = 32'hBEEF_1234; fetch `inst_addr`=0x10, `inst_regce` next cycle → `inst`=16'h1234 two cycles later; `inst_addr`=0x12 → 16'hBEEF.
- Store `addr`=0x40, `wmask`=4'b0011, `wdata`=32'h0000_5A5A over 32'hFFFF_FFFF; load 0x40 → `rdata`=32'hFFFF_5A5A one cycle after `rreq`, 0 the cycle after; concurrent fetch yields `inst_lat`=0.
- Store 32'h0 to 0xfffffffc → `exit_valid` one pulse, `halted`=1, `exit_code`=0; later store 32'h7 there → `exit_code` stays 0; `sram_en` stays 0.
- Load 0x0001_0000 → `rdata`=0, `bus_err`=1; `rreq` with `wmask`=4'hf to 0x20 → store done, `rdata`=0, `bus_err` stays 1.
- Assert `reset` during a load cycle → `rdata`=0, `inst`=0, `halted`=0 immediately; after release, first `sram_addr` = `inst_addr[PC_BITS-1:2]`.
